// File: rtl/instr_fetch_if.sv
// Fetch-unit bus bundle: the instruction-memory read port, the redirect port
// and the decode-side valid/ready output, all in one interface.
// Ports:
//   mem_addr/mem_rdata        - instruction memory address out, read data back
//   redirect_valid/pc         - branch/jump target load
//   out_valid/ready/instr/pc  - fetched word and its PC toward decode
// Modports: master = the fetch unit, slave = memory/decode/redirect side.
interface instr_fetch_if #(
    parameter int addr_width = 9,
    parameter int data_width = 32
);
    logic [addr_width-1:0] mem_addr;
    logic [data_width-1:0] mem_rdata;
    logic                  redirect_valid;
    logic [addr_width-1:0] redirect_pc;
    logic                  out_valid;
    logic                  out_ready;
    logic [data_width-1:0] out_instr;
    logic [addr_width-1:0] out_pc;

    modport master (
        output mem_addr,
        input  mem_rdata,
        input  redirect_valid,
        input  redirect_pc,
        output out_valid,
        input  out_ready,
        output out_instr,
        output out_pc
    );

    modport slave (
        input  mem_addr,
        output mem_rdata,
        output redirect_valid,
        output redirect_pc,
        input  out_valid,
        output out_ready,
        input  out_instr,
        input  out_pc
    );
endinterface

// File: rtl/instr_fetch.sv
// Instruction fetch: owns the PC, reads a 2-cycle-latency instruction memory, queues {instr, pc}.
// Latency: 3 cycles from address issue to out_valid; redirect target appears 4 cycles after redirect.
// Backpressure: output FIFO absorbs decode stalls; issue stops once FIFO + in-flight reads reach fifo_depth.
//
// Ports:
//   clk  - system clock, all state on the rising edge
//   rst  - synchronous active-high reset (overrides redirect and handshakes)
//   bus  - instr_fetch_if.master: memory read port, redirect port, decode output
module instr_fetch #(
    parameter int                  addr_width = 9,
    parameter int                  data_width = 32,
    parameter logic [addr_width-1:0] reset_pc = '0,
    parameter int                  fifo_depth = 4
) (
    input  logic          clk,
    input  logic          rst,
    instr_fetch_if.master bus
);

    localparam int ptr_w = (fifo_depth > 1) ? $clog2(fifo_depth) : 1;
    localparam int cnt_w = $clog2(fifo_depth + 1);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [addr_width-1:0] pc;

    // In-flight read pipeline: s1 = address presented last edge,
    // s2 = data for it is on mem_rdata this cycle.
    logic                  s1_v;
    logic [addr_width-1:0] s1_pc;
    logic                  s2_v;
    logic [addr_width-1:0] s2_pc;

    // Output queue storage and bookkeeping.
    logic [data_width-1:0] fifo_instr [fifo_depth];
    logic [addr_width-1:0] fifo_pc    [fifo_depth];
    logic [ptr_w-1:0]      head;
    logic [ptr_w-1:0]      tail;
    logic [cnt_w-1:0]      count;

    // ------------------------------------------------------------------
    // Combinational control
    // ------------------------------------------------------------------
    logic [cnt_w:0]        occupancy;
    logic                  issue;
    logic                  push;
    logic                  pop;
    logic [addr_width-1:0] redirect_target;
    logic [addr_width-1:0] pc_plus4;

    // The low two bits of the redirect target are dropped on purpose.
    logic unused_redirect_lsbs;
    assign unused_redirect_lsbs = ^bus.redirect_pc[1:0];

    function automatic logic [ptr_w-1:0] ptr_next(input logic [ptr_w-1:0] p);
        // Explicit wrap so non-power-of-two depths stay in range.
        if (p == ptr_w'(fifo_depth - 1)) begin
            return '0;
        end
        return p + ptr_w'(1);
    endfunction

    always_comb begin
        // Every slot that a queued word or an outstanding read could land in
        // is reserved. A pop in the same cycle is deliberately not credited,
        // which keeps the check free of any path from out_ready.
        occupancy       = {1'b0, count}
                        + {{cnt_w{1'b0}}, s1_v}
                        + {{cnt_w{1'b0}}, s2_v};
        issue           = (occupancy < (cnt_w + 1)'(fifo_depth)) && !bus.redirect_valid;
        push            = s2_v;
        pop             = (count != '0) && bus.out_ready;
        redirect_target = {bus.redirect_pc[addr_width-1:2], 2'b00};
        // Natural modulo-2^addr_width wrap: top word wraps to address 0.
        pc_plus4        = pc + addr_width'(4);
    end

    // ------------------------------------------------------------------
    // PC and in-flight pipeline
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            pc    <= reset_pc;
            s1_v  <= 1'b0;
            s1_pc <= '0;
            s2_v  <= 1'b0;
            s2_pc <= '0;
        end else if (bus.redirect_valid) begin
            // Squash both outstanding reads; their data returns but is
            // never captured because the valid bits are gone.
            pc    <= redirect_target;
            s1_v  <= 1'b0;
            s2_v  <= 1'b0;
        end else begin
            if (issue) begin
                pc    <= pc_plus4;
                s1_v  <= 1'b1;
                s1_pc <= pc;
            end else begin
                // Memory still sees pc this cycle; the read is simply ignored.
                s1_v  <= 1'b0;
            end
            s2_v  <= s1_v;
            s2_pc <= s1_pc;
        end
    end

    // ------------------------------------------------------------------
    // Output FIFO
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
            for (int i = 0; i < fifo_depth; i++) begin
                fifo_instr[i] <= '0;
                fifo_pc[i]    <= '0;
            end
        end else if (bus.redirect_valid) begin
            // Flush; a handshake this cycle is still a completed transfer
            // from decode's point of view, nothing else needs to happen.
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            // The issue reservation guarantees space whenever push is high.
            if (push) begin
                fifo_instr[tail] <= bus.mem_rdata;
                fifo_pc[tail]    <= s2_pc;
                tail             <= ptr_next(tail);
            end
            if (pop) begin
                head <= ptr_next(head);
            end
            unique case ({push, pop})
                2'b10:   count <= count + cnt_w'(1);
                2'b01:   count <= count - cnt_w'(1);
                default: count <= count;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign bus.mem_addr  = pc;
    assign bus.out_valid = (count != '0);
    assign bus.out_instr = fifo_instr[head];
    assign bus.out_pc    = fifo_pc[head];

endmodule
